// File: rtl/timer_ctrl_if.sv
// Front-panel bundle between the board buttons,
// the timer core and the display decoders.
interface timer_ctrl_if;
  logic       btn_start;
  logic       btn_clear;
  logic       btn_lap;
  logic [5:0] min;
  logic [5:0] sec;
  logic [1:0] cmd;
  logic [1:0] state;
  logic [5:0] disp_min;
  logic [5:0] disp_sec;

  modport master (
    output btn_start, btn_clear, btn_lap,
    output min, sec,
    input  cmd, state, disp_min, disp_sec
  );

  modport slave (
    input  btn_start, btn_clear, btn_lap,
    input  min, sec,
    output cmd, state, disp_min, disp_sec
  );
endinterface

// File: rtl/timer_ctrl.sv
// Stopwatch front panel: button sync/debounce,
// press detection, run/pause/lap FSM, lap display.
module timer_ctrl #(
  parameter int DEB_CYCLES = 50000
) (
  input logic      clk,
  input logic      rst,
  timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    COUNT = 2'b01,
    CLEAR = 2'b10
  } cmd_t;

  localparam logic [15:0] DEB_LAST =
    16'(DEB_CYCLES - 1);

  // bit 0 start, bit 1 clear, bit 2 lap
  logic [2:0]  raw;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  level;
  logic [2:0]  level_q;
  logic [2:0]  pulse;
  logic [15:0] cnt [3];

  state_t      state_q;
  cmd_t        cmd_q;
  logic [5:0]  lap_min;
  logic [5:0]  lap_sec;

  logic        win_clr;
  logic        win_start;
  logic        win_lap;
  logic        at_limit;

  assign raw = {bus.btn_lap,
                bus.btn_clear,
                bus.btn_start};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
      for (int i = 0; i < 3; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          level[i] <= ~level[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
      pulse   <= '0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

  // one winner per cycle: clear > start > lap
  assign win_clr   = pulse[1];
  assign win_start = pulse[0] & ~pulse[1];
  assign win_lap   = pulse[2] & ~|pulse[1:0];
  assign at_limit  = (bus.min == 6'd59) &&
                     (bus.sec == 6'd59);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cmd_q   <= HOLD;
      lap_min <= '0;
      lap_sec <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_clr) begin
            cmd_q <= CLEAR;
          end else if (win_start) begin
            state_q <= RUN;
            cmd_q   <= COUNT;
          end else begin
            cmd_q <= HOLD;
          end
        end
        PAUSE: begin
          if (win_clr) begin
            state_q <= IDLE;
            cmd_q   <= CLEAR;
          end else if (win_start && !at_limit) begin
            state_q <= RUN;
            cmd_q   <= COUNT;
          end else begin
            cmd_q <= HOLD;
          end
        end
        RUN, LAP: begin
          if (win_clr) begin
            state_q <= IDLE;
            cmd_q   <= CLEAR;
          end else if (at_limit || win_start) begin
            state_q <= PAUSE;
            cmd_q   <= HOLD;
          end else if (win_lap) begin
            cmd_q <= COUNT;
            if (state_q == RUN) begin
              state_q <= LAP;
              lap_min <= bus.min;
              lap_sec <= bus.sec;
            end else begin
              state_q <= RUN;
            end
          end else begin
            cmd_q <= COUNT;
          end
        end
        default: begin
          state_q <= IDLE;
          cmd_q   <= HOLD;
        end
      endcase
    end
  end

  assign bus.state = state_q;
  assign bus.cmd   = cmd_q;

  assign bus.disp_min = (state_q == LAP) ?
                        lap_min : bus.min;
  assign bus.disp_sec = (state_q == LAP) ?
                        lap_sec : bus.sec;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed panel scenarios then
// random button/time traffic against a reference model.
module tb_timer_ctrl;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  timer_ctrl_if bus ();

  timer_ctrl #(.DEB_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model: raw sample history per button,
  // level flips once the last D synchronised samples
  // all disagree with it
  int        m_state;
  int        m_cmd;
  int        m_lap_min;
  int        m_lap_sec;
  bit [2:0]  m_lvl;
  bit [2:0]  m_lvl_prev;
  bit [2:0]  m_pulse;
  bit [63:0] m_hist [3];

  function automatic void model_reset();
    m_state    = 0;
    m_cmd      = 0;
    m_lap_min  = 0;
    m_lap_sec  = 0;
    m_lvl      = '0;
    m_lvl_prev = '0;
    m_pulse    = '0;
    for (int b = 0; b < 3; b++)
      m_hist[b] = '0;
  endfunction

  function automatic void model_edge();
    bit [2:0] raw;
    bit [2:0] nl;
    bit       clr, st, lp, lim, diff;
    int       ns, nc;
    raw = {bus.btn_lap, bus.btn_clear,
           bus.btn_start};
    clr = m_pulse[1];
    st  = m_pulse[0] && !clr;
    lp  = m_pulse[2] && !clr && !m_pulse[0];
    lim = (bus.min == 59) && (bus.sec == 59);
    ns  = m_state;
    nc  = 0;
    if (m_state == 0) begin
      if (clr) nc = 2;
      else if (st) begin ns = 1; nc = 1; end
    end else if (m_state == 2) begin
      if (clr) begin ns = 0; nc = 2; end
      else if (st && !lim) begin
        ns = 1; nc = 1;
      end
    end else begin
      nc = 1;
      if (clr) begin ns = 0; nc = 2; end
      else if (lim || st) begin ns = 2; nc = 0; end
      else if (lp) begin
        ns = (m_state == 1) ? 3 : 1;
        if (m_state == 1) begin
          m_lap_min = int'(bus.min);
          m_lap_sec = int'(bus.sec);
        end
      end
    end
    for (int b = 0; b < 3; b++) begin
      diff = 1'b1;
      for (int j = 0; j < D; j++)
        if (m_hist[b][1+j] == m_lvl[b]) diff = 1'b0;
      nl[b] = diff ? ~m_lvl[b] : m_lvl[b];
      m_hist[b] = {m_hist[b][62:0], raw[b]};
    end
    m_pulse    = m_lvl & ~m_lvl_prev;
    m_lvl_prev = m_lvl;
    m_lvl      = nl;
    m_state    = ns;
    m_cmd      = nc;
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int em, es;
    em = (m_state == 3) ? m_lap_min : int'(bus.min);
    es = (m_state == 3) ? m_lap_sec : int'(bus.sec);
    chk("state", 8'(bus.state), 8'(m_state));
    chk("cmd", 8'(bus.cmd), 8'(m_cmd));
    chk("disp_min", 8'(bus.disp_min), 8'(em));
    chk("disp_sec", 8'(bus.disp_sec), 8'(es));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_btn(input bit [2:0] b);
    bus.btn_start = b[0];
    bus.btn_clear = b[1];
    bus.btn_lap   = b[2];
  endtask

  task automatic press(input bit [2:0] b);
    set_btn(b);
    run(D + 4);
    set_btn(3'b000);
    run(D + 4);
  endtask

  task automatic clear_check(input string tag);
    set_btn(3'b010);
    run(D + 3);
    chk({tag, "_pre"}, 8'(bus.cmd == 2'b10), 8'd0);
    run(1);
    chk({tag, "_clr"}, 8'(bus.cmd), 8'd2);
    run(1);
    chk({tag, "_hold"}, 8'(bus.cmd), 8'd0);
    chk({tag, "_idle"}, 8'(bus.state), 8'd0);
    set_btn(3'b000);
    run(D + 4);
  endtask

  initial begin
    model_reset();
    bus.min = 6'd12;
    bus.sec = 6'd34;
    set_btn(3'b000);

    // reset held, buttons wiggling
    repeat (8) begin
      @(negedge clk);
      set_btn(3'($urandom));
      step();
      chk("rst_dmin", 8'(bus.disp_min), 8'd12);
      chk("rst_dsec", 8'(bus.disp_sec), 8'd34);
    end
    set_btn(3'b000);
    rst = 1'b1;
    run(20);
    chk("post_rst", 8'(bus.state), 8'd0);

    // short bounce, then a real press
    set_btn(3'b001);
    run(3);
    set_btn(3'b000);
    run(10);
    chk("bounce", 8'(bus.state), 8'd0);
    set_btn(3'b001);
    run(D + 3);
    chk("deb_early", 8'(bus.state), 8'd0);
    run(1);
    chk("deb_state", 8'(bus.state), 8'd1);
    chk("deb_cmd", 8'(bus.cmd), 8'd1);
    run(50);
    chk("deb_held", 8'(bus.state), 8'd1);
    set_btn(3'b000);
    run(D + 4);

    // lap capture and return
    bus.min = 6'd3;
    bus.sec = 6'd17;
    set_btn(3'b100);
    run(D + 4);
    chk("lap_state", 8'(bus.state), 8'd3);
    set_btn(3'b000);
    bus.sec = 6'd18;
    run(1);
    chk("lap_s18", 8'(bus.disp_sec), 8'd17);
    bus.sec = 6'd19;
    run(1);
    chk("lap_s19", 8'(bus.disp_sec), 8'd17);
    chk("lap_min", 8'(bus.disp_min), 8'd3);
    chk("lap_cmd", 8'(bus.cmd), 8'd1);
    run(D + 4);
    set_btn(3'b100);
    run(D + 4);
    chk("unlap", 8'(bus.state), 8'd1);
    chk("unlap_d", 8'(bus.disp_sec), 8'd19);
    set_btn(3'b000);
    run(D + 4);

    // clear from RUN, PAUSE, LAP
    clear_check("clr_run");
    press(3'b001);
    press(3'b001);
    chk("pause", 8'(bus.state), 8'd2);
    clear_check("clr_pause");
    press(3'b001);
    press(3'b100);
    chk("lap2", 8'(bus.state), 8'd3);
    clear_check("clr_lap");

    // start and clear together in PAUSE
    press(3'b001);
    press(3'b001);
    set_btn(3'b011);
    run(D + 4);
    chk("sim_state", 8'(bus.state), 8'd0);
    chk("sim_cmd", 8'(bus.cmd), 8'd2);
    run(1);
    chk("sim_hold", 8'(bus.cmd), 8'd0);
    set_btn(3'b000);
    run(D + 4);

    // 59:59 limit
    bus.min = 6'd10;
    bus.sec = 6'd0;
    press(3'b001);
    bus.min = 6'd59;
    bus.sec = 6'd59;
    run(1);
    chk("lim_state", 8'(bus.state), 8'd2);
    chk("lim_cmd", 8'(bus.cmd), 8'd0);
    press(3'b001);
    chk("lim_start", 8'(bus.state), 8'd2);
    clear_check("lim_clr");

    // asynchronous reset mid-RUN
    bus.min = 6'd1;
    bus.sec = 6'd2;
    press(3'b001);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_state", 8'(bus.state), 8'd0);
    chk("arst_cmd", 8'(bus.cmd), 8'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    run(5);

    // random traffic
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 9) == 0)
        bus.btn_start = ~bus.btn_start;
      if ($urandom_range(0, 24) == 0)
        bus.btn_clear = ~bus.btn_clear;
      if ($urandom_range(0, 9) == 0)
        bus.btn_lap = ~bus.btn_lap;
      if ($urandom_range(0, 15) == 0) begin
        bus.min = 6'd59;
        bus.sec = 6'd59;
      end else begin
        bus.min = 6'($urandom_range(0, 59));
        bus.sec = 6'($urandom_range(0, 59));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Front-panel controller for the min/sec timer. Takes three raw pushbuttons (start/stop, clear, lap), synchronises and debounces them, and runs a stopwatch state machine. The state machine drives the timer's 2-bit command input. Sits between the board buttons and the timer core; its display outputs feed the four hex decoders in place of the timer's live min/sec.

## Interface
- DEB_CYCLES, 50000: consecutive stable samples required to accept a new button level; range 1..65535 (16-bit counter).

- clk  in  1  system clock; same clock as the timer core.
- rst  in  1  asynchronous, active-low reset.
- btn_start  in  1  raw start/stop button, active-high, asynchronous to clk.
- btn_clear  in  1  raw clear button, active-high, asynchronous.
- btn_lap  in  1  raw lap button, active-high, asynchronous.
- min  in  6  current minutes from timer core, 0..59.
- sec  in  6  current seconds from timer core, 0..59.
- cmd  out  2  timer command: 00 HOLD, 01 COUNT, 10 CLEAR; 11 never driven.
- state  out  2  controller state: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP.
- disp_min  out  6  minutes to display.
- disp_sec  out  6  seconds to display.

## Operation
- Per button: 2-FF synchroniser, then debouncer.
  - The debouncer holds a debounced level (reset 0) and a 16-bit counter.
  - When the synchronised sample differs from the debounced level, the counter increments; any sample equal to the debounced level clears it.
  - When the counter reaches DEB_CYCLES, the debounced level toggles and the counter clears.
- A rising edge of a debounced level produces a registered 1-cycle press pulse. Release produces nothing.
- Priority when pulses coincide in one cycle: clear > start > lap. Only the winning pulse acts; the others are dropped.
- FSM; cmd and state are registered:
  - IDLE: cmd HOLD.
    - start → RUN.
    - clear → stays IDLE, with cmd CLEAR for exactly one cycle.
    - lap ignored.
  - RUN: cmd COUNT.
    - start → PAUSE.
    - lap → LAP; min/sec are captured into the lap registers on that edge.
    - clear → IDLE, with cmd CLEAR for one cycle, then HOLD.
  - PAUSE: cmd HOLD.
    - start → RUN, except when min=59 and sec=59, where start is ignored.
    - clear → IDLE + CLEAR pulse.
    - lap ignored.
  - LAP: cmd COUNT; the timer keeps running.
    - lap → RUN.
    - start → PAUSE.
    - clear → IDLE + CLEAR pulse.
- Limit: in RUN or LAP, when min=59 and sec=59 is sampled, the next state is PAUSE and cmd becomes HOLD. This takes precedence over lap and start pulses in the same cycle; clear still wins.
- Display:
  - In LAP: disp_min/disp_sec = lap registers.
  - Otherwise: combinational pass-through of min/sec.
- Lap registers reset to 0 and are written only on the RUN→LAP transition.

## Timing
- Reset (rst=0), asynchronous and immediate:
  - state 00, cmd 00.
  - Debounced levels 0, counters 0, pulses 0, lap registers 0.
  - disp = min/sec.
- Button latency: raw input changes between edges k and k+1 and stays stable. Then:
  - sync output is new after edge k+2;
  - debounced level toggles at edge k+2+DEB_CYCLES;
  - press pulse is high after edge k+3+DEB_CYCLES;
  - state/cmd update at edge k+4+DEB_CYCLES.
- A bounce shorter than DEB_CYCLES samples produces no pulse and no state change.
- A button held through reset release is seen as one press DEB_CYCLES+4 cycles after release.
- A held button produces exactly one pulse; the next press requires a debounced release first.
- CLEAR on cmd is exactly one clk cycle wide. The timer core must sample cmd on clk.
- disp switches to the lap registers on the same edge state becomes 11, and back on the edge state leaves 11.

## Test plan
All scenarios run with DEB_CYCLES=4.

1. Reset: hold rst=0 with min=12, sec=34, buttons at random levels → state=00, cmd=00, disp=12/34 throughout. Release rst with all buttons low → no change for 20 cycles.
2. Debounce: in IDLE, btn_start high for 3 cycles then low → no change. Then btn_start high from just after edge k → cmd=01 and state=01 at edge k+8, and nothing further while held 50 cycles.
3. Lap: in RUN with min=3, sec=17, press lap → state=11, disp=3/17 while sec input steps 18, 19, and cmd stays 01. Press lap again → state=01, disp follows live input.
4. Clear: in RUN press clear → cmd=10 for exactly one cycle, then 00, state=00. Repeat from PAUSE and from LAP with the same result.
5. Simultaneous: in PAUSE, assert btn_start and btn_clear on the same edge → only clear acts: state=00 and one CLEAR cycle, no RUN.
6. Limit: in RUN, drive min=59, sec=59 → next edge state=10, cmd=00. A start press while 59:59 holds → state stays 10. A clear press → state=00 plus one CLEAR cycle.
